// File: rtl/dual_port_ram_be_pkg.sv
// rtl/dual_port_ram_be_pkg.sv - write-mode codes, clear FSM states and lane-merge helper for dual_port_ram_be
package dual_port_ram_be_pkg;

  localparam int WM_WRITE_FIRST = 0;
  localparam int WM_READ_FIRST  = 1;
  localparam int WM_NO_CHANGE   = 2;

  // Widest word the merge helper handles; callers zero-extend into it.
  localparam int MAX_DATA_WIDTH = 1024;

  typedef enum logic {
    CLEAR,
    READY
  } ram_state_e;

  function automatic logic [MAX_DATA_WIDTH-1:0] merge_lanes(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_DATA_WIDTH-1:0] lane_mask
  );
    return (old_word & ~lane_mask) | (new_word & lane_mask);
  endfunction

endpackage

// File: rtl/dual_port_ram_be_rdpipe.sv
// rtl/dual_port_ram_be_rdpipe.sv - per-port read data/valid pipeline, one or two register stages
module dual_port_ram_be_rdpipe
  import dual_port_ram_be_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUTPUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dvalid
);

  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_valid_q, s1_valid_d;

  always_comb begin
    s1_data_d  = ld ? ld_data : s1_data_q;
    s1_valid_d = ld;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  if (OUTPUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
    logic                  s2_valid_q, s2_valid_d;

    // Second stage only captures real read results so dout holds across idle cycles.
    always_comb begin
      s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
      s2_valid_d = s1_valid_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_data_q  <= '0;
        s2_valid_q <= 1'b0;
      end else begin
        s2_data_q  <= s2_data_d;
        s2_valid_q <= s2_valid_d;
      end
    end

    assign dout   = s2_data_q;
    assign dvalid = s2_valid_q;
  end else begin : g_no_out_reg
    assign dout   = s1_data_q;
    assign dvalid = s1_valid_q;
  end

endmodule

// File: rtl/dual_port_ram_be.sv
// rtl/dual_port_ram_be.sv - single-clock true dual-port byte-enable RAM with clear sweep; DUAL_PORT_RAM_BE_COLLISION_FWD_EN forwards colliding writes to the reader
module dual_port_ram_be
  import dual_port_ram_be_pkg::*;
#(
  parameter int                   DATA_WIDTH     = 32,
  parameter int                   BYTE_WIDTH     = 8,
  parameter int                   ADDR_WIDTH     = 10,
  parameter string                WRITE_MODE_A   = "READ_FIRST",
  parameter string                WRITE_MODE_B   = "READ_FIRST",
  parameter int                   OUTPUT_REG_A   = 0,
  parameter int                   OUTPUT_REG_B   = 0,
  parameter int                   CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             init_busy,
  input  logic                             a_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_we,
  input  logic [ADDR_WIDTH-1:0]            a_addr,
  input  logic [DATA_WIDTH-1:0]            a_din,
  output logic [DATA_WIDTH-1:0]            a_dout,
  output logic                             a_dvalid,
  input  logic                             b_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] b_we,
  input  logic [ADDR_WIDTH-1:0]            b_addr,
  input  logic [DATA_WIDTH-1:0]            b_din,
  output logic [DATA_WIDTH-1:0]            b_dout,
  output logic                             b_dvalid,
  output logic                             collision
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int WM_A  = (WRITE_MODE_A == "WRITE_FIRST") ? WM_WRITE_FIRST :
                         (WRITE_MODE_A == "NO_CHANGE")   ? WM_NO_CHANGE : WM_READ_FIRST;
  localparam int WM_B  = (WRITE_MODE_B == "WRITE_FIRST") ? WM_WRITE_FIRST :
                         (WRITE_MODE_B == "NO_CHANGE")   ? WM_NO_CHANGE : WM_READ_FIRST;
  localparam ram_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [DATA_WIDTH-1:0] lane_mask
  );
    return DATA_WIDTH'(merge_lanes(MAX_DATA_WIDTH'(old_word), MAX_DATA_WIDTH'(new_word),
                                   MAX_DATA_WIDTH'(lane_mask)));
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  collision_q, collision_d;

  logic                  ready, clr_we;
  logic                  a_act, b_act, a_wr, b_wr, same_addr;
  logic [DATA_WIDTH-1:0] a_mask, b_mask;
  logic [DATA_WIDTH-1:0] a_old, b_old, a_own, b_own, both_word;
  logic                  a_ld, b_ld;
  logic [DATA_WIDTH-1:0] a_rd_data, b_rd_data;

  for (genvar l = 0; l < NB; l++) begin : g_mask
    assign a_mask[l*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{a_we[l]}};
    assign b_mask[l*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{b_we[l]}};
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == CLEAR) begin
      clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
      if (&clr_addr_q) begin
        state_d = READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      clr_addr_q  <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      collision_q <= collision_d;
    end
  end

  // User traffic is blocked while sweeping and during the reset cycle itself.
  assign ready     = (state_q == READY) && !rst;
  assign clr_we    = (state_q == CLEAR) && !rst;
  assign a_act     = a_en && ready;
  assign b_act     = b_en && ready;
  assign a_wr      = a_act && (a_we != '0);
  assign b_wr      = b_act && (b_we != '0);
  assign same_addr = (a_addr == b_addr);

  assign a_old     = mem_q[a_addr];
  assign b_old     = mem_q[b_addr];
  assign a_own     = lane_merge(a_old, a_din, a_mask);
  assign b_own     = lane_merge(b_old, b_din, b_mask);
  // Word stored at the shared address when both ports hit it: A lanes override B lanes.
  assign both_word = lane_merge(lane_merge(a_old, b_din, b_mask), a_din, a_mask);

  assign collision_d = a_act && b_act && same_addr && (a_wr || b_wr);

  always_comb begin
    a_ld      = a_act && !(a_wr && (WM_A == WM_NO_CHANGE));
    b_ld      = b_act && !(b_wr && (WM_B == WM_NO_CHANGE));
    a_rd_data = (a_wr && (WM_A == WM_WRITE_FIRST)) ? a_own : a_old;
    b_rd_data = (b_wr && (WM_B == WM_WRITE_FIRST)) ? b_own : b_old;
`ifdef DUAL_PORT_RAM_BE_COLLISION_FWD_EN
    if (collision_d && b_wr) begin
      a_rd_data = both_word;
    end
    if (collision_d && a_wr) begin
      b_rd_data = both_word;
    end
`endif
  end

  // Port A lanes are written after port B lanes so A wins on shared lanes.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr_q] <= CLEAR_VALUE;
    end
    for (int l = 0; l < NB; l++) begin
      if (b_wr && b_we[l]) begin
        mem_q[b_addr][l*BYTE_WIDTH +: BYTE_WIDTH] <= b_din[l*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    for (int l = 0; l < NB; l++) begin
      if (a_wr && a_we[l]) begin
        mem_q[a_addr][l*BYTE_WIDTH +: BYTE_WIDTH] <= a_din[l*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  dual_port_ram_be_rdpipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUTPUT_REG(OUTPUT_REG_A)
  ) u_rdpipe_a (
    .clk    (clk),
    .rst    (rst),
    .ld     (a_ld),
    .ld_data(a_rd_data),
    .dout   (a_dout),
    .dvalid (a_dvalid)
  );

  dual_port_ram_be_rdpipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUTPUT_REG(OUTPUT_REG_B)
  ) u_rdpipe_b (
    .clk    (clk),
    .rst    (rst),
    .ld     (b_ld),
    .ld_data(b_rd_data),
    .dout   (b_dout),
    .dvalid (b_dvalid)
  );

  assign init_busy = (state_q == CLEAR);
  assign collision = collision_q;

endmodule

// File: tb/tb_dual_port_ram_be.sv
// tb/tb_dual_port_ram_be.sv - randomized self-checking bench for dual_port_ram_be against a behavioural memory model
`timescale 1ns/1ps
module tb_dual_port_ram_be;

  localparam int DW    = 32;
  localparam int NB    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] CLR = 32'hA5A5A5A5;
  localparam int WF = 0;
  localparam int RF = 1;
  localparam int NC = 2;
`ifdef DUAL_PORT_RAM_BE_COLLISION_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_en, b_en;
  logic [NB-1:0] a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din;

  logic          d0_busy, d0_coll, d0_a_v, d0_b_v, d1_busy, d1_coll, d1_a_v, d1_b_v;
  logic [DW-1:0] d0_a_d, d0_b_d, d1_a_d, d1_b_d;

  // dut0: A WRITE_FIRST latency 1, B NO_CHANGE latency 2
  dual_port_ram_be #(
    .DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW),
    .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("NO_CHANGE"),
    .OUTPUT_REG_A(0), .OUTPUT_REG_B(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR)
  ) dut0 (
    .clk(clk), .rst(rst), .init_busy(d0_busy),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(d0_a_d), .a_dvalid(d0_a_v),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(d0_b_d), .b_dvalid(d0_b_v),
    .collision(d0_coll)
  );

  // dut1: both READ_FIRST, A latency 2, B latency 1
  dual_port_ram_be #(
    .DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW),
    .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("READ_FIRST"),
    .OUTPUT_REG_A(1), .OUTPUT_REG_B(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR)
  ) dut1 (
    .clk(clk), .rst(rst), .init_busy(d1_busy),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(d1_a_d), .a_dvalid(d1_a_v),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(d1_b_d), .b_dvalid(d1_b_v),
    .collision(d1_coll)
  );

  logic          obs_v [2][2];
  logic [DW-1:0] obs_d [2][2];
  logic          obs_busy [2];
  logic          obs_coll [2];
  always_comb begin
    obs_v[0][0] = d0_a_v; obs_v[0][1] = d0_b_v; obs_v[1][0] = d1_a_v; obs_v[1][1] = d1_b_v;
    obs_d[0][0] = d0_a_d; obs_d[0][1] = d0_b_d; obs_d[1][0] = d1_a_d; obs_d[1][1] = d1_b_d;
    obs_busy[0] = d0_busy; obs_busy[1] = d1_busy;
    obs_coll[0] = d0_coll; obs_coll[1] = d1_coll;
  end

  function automatic int mode_of(input int d, input int p);
    if (d == 0) return (p == 0) ? WF : NC;
    return RF;
  endfunction

  function automatic int lat_of(input int d, input int p);
    if (d == 0) return (p == 0) ? 1 : 2;
    return (p == 0) ? 2 : 1;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: memory contents plus the read results each port owes, by age.
  logic [DW-1:0] mm [DEPTH];
  bit            hv [2][2][2];
  logic [DW-1:0] hd [2][2][2];
  bit            ev [2][2];
  logic [DW-1:0] ed [2][2];
  bit            ecoll;

  function automatic logic [DW-1:0] put_lanes(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                              input logic [NB-1:0] we);
    logic [DW-1:0] r;
    r = o;
    for (int k = 0; k < NB; k++) begin
      if (we[k]) r[8*k +: 8] = n[8*k +: 8];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mm[i] = CLR;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        ev[d][p] = 1'b0;
        ed[d][p] = '0;
        for (int k = 0; k < 2; k++) begin
          hv[d][p][k] = 1'b0;
          hd[d][p][k] = '0;
        end
      end
    end
    ecoll = 1'b0;
  endtask

  task automatic set_idle();
    a_en = 1'b0; a_we = '0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_we = '0; b_addr = '0; b_din = '0;
  endtask

  function automatic logic [NB-1:0] rnd_we();
    return ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0;
  endfunction

  task automatic drive_random(input int amax);
    a_en = 1'($urandom); a_we = rnd_we(); a_addr = AW'($urandom_range(0, amax)); a_din = $urandom;
    b_en = 1'($urandom); b_we = rnd_we(); b_addr = AW'($urandom_range(0, amax)); b_din = $urandom;
  endtask

  // One user cycle: drive at a negedge, advance the model, check at the next negedge.
  task automatic step(input logic ae, input logic [NB-1:0] awe, input logic [AW-1:0] aad,
                      input logic [DW-1:0] ad, input logic be, input logic [NB-1:0] bwe,
                      input logic [AW-1:0] bad, input logic [DW-1:0] bd);
    logic [DW-1:0] nxt [DEPTH];
    bit            en [2], wr [2], same, coll_now, v;
    logic [NB-1:0] we [2];
    logic [AW-1:0] adr [2];
    logic [DW-1:0] din [2], old [2], own [2], data;
    int            k;
    a_en = ae; a_we = awe; a_addr = aad; a_din = ad;
    b_en = be; b_we = bwe; b_addr = bad; b_din = bd;
    en[0] = ae; we[0] = awe; adr[0] = aad; din[0] = ad;
    en[1] = be; we[1] = bwe; adr[1] = bad; din[1] = bd;
    nxt = mm;
    for (int p = 0; p < 2; p++) begin
      wr[p]  = en[p] && (we[p] != '0);
      old[p] = mm[adr[p]];
      own[p] = put_lanes(old[p], din[p], we[p]);
    end
    if (wr[1]) nxt[adr[1]] = put_lanes(nxt[adr[1]], din[1], we[1]);
    if (wr[0]) nxt[adr[0]] = put_lanes(nxt[adr[0]], din[0], we[0]);
    same     = ae && be && (aad == bad);
    coll_now = same && (wr[0] || wr[1]);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        v = en[p] && !(wr[p] && mode_of(d, p) == NC);
        if (FWD && same && wr[1-p]) data = nxt[adr[p]];
        else if (wr[p] && mode_of(d, p) == WF) data = own[p];
        else data = old[p];
        hv[d][p][1] = hv[d][p][0]; hd[d][p][1] = hd[d][p][0];
        hv[d][p][0] = v;           hd[d][p][0] = data;
        k = lat_of(d, p) - 1;
        ev[d][p] = hv[d][p][k];
        if (hv[d][p][k]) ed[d][p] = hd[d][p][k];
      end
    end
    ecoll = coll_now;
    mm = nxt;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_busy", d), DW'(obs_busy[d]), '0);
      check($sformatf("d%0d_collision", d), DW'(obs_coll[d]), DW'(ecoll));
      for (int p = 0; p < 2; p++) begin
        check($sformatf("d%0d_p%0d_dvalid", d, p), DW'(obs_v[d][p]), DW'(ev[d][p]));
        check($sformatf("d%0d_p%0d_dout", d, p), obs_d[d][p], ed[d][p]);
      end
    end
  endtask

  task automatic rand_step();
    step(1'($urandom), rnd_we(), AW'($urandom_range(0, 3)), $urandom,
         1'($urandom), rnd_we(), AW'($urandom_range(0, 3)), $urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_d%0d_collision", tag, d), DW'(obs_coll[d]), '0);
      check($sformatf("%s_d%0d_busy", tag, d), DW'(obs_busy[d]), DW'(1));
      for (int p = 0; p < 2; p++) begin
        check($sformatf("%s_d%0d_p%0d_dvalid", tag, d, p), DW'(obs_v[d][p]), '0);
        check($sformatf("%s_d%0d_p%0d_dout", tag, d, p), obs_d[d][p], '0);
      end
    end
  endtask

  // Counts busy cycles per instance; the loop bound catches a sweep that never ends.
  task automatic count_sweep(input string tag, input bit poke);
    int n = 0;
    int nb [2];
    nb[0] = 0; nb[1] = 0;
    while ((obs_busy[0] === 1'b1 || obs_busy[1] === 1'b1) && n < 64) begin
      for (int d = 0; d < 2; d++) begin
        if (obs_busy[d] === 1'b1) nb[d]++;
        for (int p = 0; p < 2; p++) begin
          check($sformatf("%s_sweep_d%0d_p%0d_dvalid", tag, d, p), DW'(obs_v[d][p]), '0);
        end
      end
      if (poke) drive_random(DEPTH - 1);
      n++;
      @(negedge clk);
    end
    set_idle();
    check({tag, "_busy_cycles_d0"}, DW'(nb[0]), DW'(DEPTH));
    check({tag, "_busy_cycles_d1"}, DW'(nb[1]), DW'(DEPTH));
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, '0, AW'(i), '0, 1'b1, '0, AW'(DEPTH - 1 - i), '0);
    end
    step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    model_reset();
    count_sweep("clear", 1'b0);
    read_all();

    // byte-enable merge
    step(1'b1, 4'hF, 4'd3, 32'h11223344, 1'b0, '0, '0, '0);
    step(1'b1, 4'b0101, 4'd3, 32'hAABBCCDD, 1'b0, '0, '0, '0);
    step(1'b1, '0, 4'd3, '0, 1'b1, '0, 4'd3, '0);
    step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);

    // two writers on one address
    step(1'b1, 4'hF, 4'd7, 32'h0, 1'b0, '0, '0, '0);
    step(1'b1, 4'b1100, 4'd7, 32'hFFFF0000, 1'b1, 4'b0110, 4'd7, 32'h12345678);
    step(1'b1, '0, 4'd7, '0, 1'b1, '0, 4'd7, '0);
    step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);

    // writer and reader on one address
    step(1'b1, 4'hF, 4'd5, 32'h0, 1'b0, '0, '0, '0);
    step(1'b1, 4'hF, 4'd5, 32'hDEADBEEF, 1'b1, '0, 4'd5, '0);
    step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    step(1'b1, '0, 4'd5, '0, 1'b1, 4'hF, 4'd5, 32'hCAFEF00D);
    step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);

    // write modes
    step(1'b0, '0, '0, '0, 1'b1, 4'hF, 4'd9, 32'h1);
    step(1'b0, '0, '0, '0, 1'b1, '0, 4'd9, '0);
    step(1'b0, '0, '0, '0, 1'b1, 4'hF, 4'd9, 32'h2);
    step(1'b1, 4'hF, 4'd10, 32'h2, 1'b0, '0, '0, '0);
    step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);

    repeat (400) rand_step();

    // reset again, then interrupt the sweep at address 9 with user traffic present
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (9) begin
      drive_random(DEPTH - 1);
      @(negedge clk);
    end
    check("midsweep_busy_before_rst", DW'(obs_busy[0]), DW'(1));
    rst = 1'b1;
    drive_random(DEPTH - 1);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midreset");
    model_reset();
    count_sweep("restart", 1'b1);
    read_all();

    repeat (100) rand_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
